// File: rtl/dvp_frame_capture.sv
// dvp_frame_capture: brings OV7670-class parallel camera video (PCLK, VSYNC,
// HREF, DATA) into the clk domain, packs camera beats into pixels and queues
// them in a show-ahead FIFO. The FIFO drives a valid/ready stream tagged with
// start-of-frame and start-of-line. The block also generates the camera master
// clock and reports frame geometry and a sticky overflow flag.
// Optional feature: define DVP_DECIMATE_EN to add ctrl_decim (2x2 decimation).
//
// Stream handshake: pix_valid is high whenever the FIFO holds a pixel. pix_data,
// pix_sof and pix_sol stay stable while pix_valid is high. A transfer (pop)
// happens on every clk edge where pix_valid & pix_ready.
module dvp_frame_capture #(
    parameter int DATA_W        = 8,
    parameter int BYTES_PER_PIX = 2,
    parameter int FIFO_DEPTH    = 64,
    parameter int XCLK_DIV      = 2,
    parameter int CNT_W         = 12
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              cam_pclk,
    input  logic                              cam_vsync,
    input  logic                              cam_href,
    input  logic [DATA_W-1:0]                 cam_data,
    output logic                              cam_xclk,
    input  logic                              ctrl_enable,
    input  logic                              ctrl_single,
    input  logic                              ctrl_arm,
    input  logic                              ovf_clr,
`ifdef DVP_DECIMATE_EN
    input  logic                              ctrl_decim,
`endif
    output logic [BYTES_PER_PIX*DATA_W-1:0]   pix_data,
    output logic                              pix_sof,
    output logic                              pix_sol,
    output logic                              pix_valid,
    input  logic                              pix_ready,
    output logic                              busy,
    output logic                              frame_done,
    output logic                              overflow,
    output logic [CNT_W-1:0]                  line_width,
    output logic [CNT_W-1:0]                  frame_lines,
    output logic [1:0]                        dbg_state
);

    localparam int PIX_W = BYTES_PER_PIX * DATA_W;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int BW    = (BYTES_PER_PIX > 1) ? $clog2(BYTES_PER_PIX) : 1;
    localparam int HALF  = XCLK_DIV / 2;
    localparam int XW    = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BYTES_PER_PIX - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_VS = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // ---------------- camera master clock ----------------
    logic [XW-1:0] xcnt_q;
    logic          xclk_q;

    // Free-running divider: toggle every HALF clk cycles while out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            xcnt_q <= '0;
            xclk_q <= 1'b0;
        end else if (xcnt_q == XW'(HALF - 1)) begin
            xcnt_q <= '0;
            xclk_q <= ~xclk_q;
        end else begin
            xcnt_q <= xcnt_q + 1'b1;
        end
    end

    assign cam_xclk = xclk_q;

    // ---------------- input synchronisers ----------------
    // Stage [2] is an extra history flop used only for edge detection.
    logic [2:0]        pclk_q, vsync_q, href_q;
    logic [DATA_W-1:0] data_s1_q, data_s2_q;

    // Two-flop synchronisers; data goes through the same depth as pclk so the
    // sampled byte lines up with the detected pclk rise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pclk_q    <= '0;
            vsync_q   <= '0;
            href_q    <= '0;
            data_s1_q <= '0;
            data_s2_q <= '0;
        end else begin
            pclk_q    <= {pclk_q[1:0], cam_pclk};
            vsync_q   <= {vsync_q[1:0], cam_vsync};
            href_q    <= {href_q[1:0], cam_href};
            data_s1_q <= cam_data;
            data_s2_q <= data_s1_q;
        end
    end

    logic pclk_rise, href_hi, href_rise, href_fall, vs_rise, vs_fall;
    assign pclk_rise = pclk_q[1] & ~pclk_q[2];
    assign href_hi   = href_q[1];
    assign href_rise = href_q[1] & ~href_q[2];
    assign href_fall = ~href_q[1] & href_q[2];
    assign vs_rise   = vsync_q[1] & ~vsync_q[2];
    assign vs_fall   = ~vsync_q[1] & vsync_q[2];

    // ---------------- capture FSM ----------------
    state_t state_q, state_d;
    logic   frame_end;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next state; disabling capture wins over everything else.
    always_comb begin
        state_d   = state_q;
        frame_end = 1'b0;
        if (!ctrl_enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:    if (!ctrl_single || ctrl_arm) state_d = ST_WAIT_VS;
                ST_WAIT_VS: if (vs_fall) state_d = ST_CAPTURE;
                ST_CAPTURE: if (vs_rise) begin
                    frame_end = 1'b1;
                    state_d   = ctrl_single ? ST_IDLE : ST_WAIT_VS;
                end
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    logic capture_start, in_capture;
    assign capture_start = (state_q == ST_WAIT_VS) && (state_d == ST_CAPTURE);
    assign in_capture    = (state_q == ST_CAPTURE);
    assign busy          = (state_q != ST_IDLE);
    assign dbg_state     = state_q;

    // ---------------- pixel assembly and geometry counters ----------------
    logic             decim_on;
`ifdef DVP_DECIMATE_EN
    assign decim_on = ctrl_decim;
`else
    assign decim_on = 1'b0;
`endif

    logic [BW-1:0]    beat_q, beat_d;
    logic [PIX_W-1:0] shreg_q, shreg_d, shreg_shift;
    logic             sof_pend_q, sof_pend_d, sol_pend_q, sol_pend_d;
    logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d, line_cnt_q, line_cnt_d;
    logic [CNT_W-1:0] last_width_q, last_width_d;
    logic             pix_odd_q, pix_odd_d, line_odd_q, line_odd_d;
    logic             shift_en, line_kept, push;
    logic [PIX_W+1:0] push_word;

    assign shift_en    = in_capture & pclk_rise & href_hi;
    assign shreg_shift = PIX_W'({shreg_q, data_s2_q});
    assign line_kept   = !decim_on || !line_odd_q;

    // Beat packing, line/pixel counting and tag bookkeeping for the current frame.
    always_comb begin
        beat_d       = beat_q;
        shreg_d      = shreg_q;
        sof_pend_d   = sof_pend_q;
        sol_pend_d   = sol_pend_q;
        pix_cnt_d    = pix_cnt_q;
        pix_odd_d    = pix_odd_q;
        line_cnt_d   = line_cnt_q;
        line_odd_d   = line_odd_q;
        last_width_d = last_width_q;
        push         = 1'b0;
        push_word    = '0;
        if (capture_start) begin
            sof_pend_d   = 1'b1;
            sol_pend_d   = 1'b0;
            beat_d       = '0;
            pix_cnt_d    = '0;
            pix_odd_d    = 1'b0;
            line_cnt_d   = '0;
            line_odd_d   = 1'b0;
            last_width_d = '0;
        end else if (in_capture) begin
            if (href_rise) begin
                beat_d     = '0;
                sol_pend_d = 1'b1;
                pix_cnt_d  = '0;
                pix_odd_d  = 1'b0;
            end
            if (href_fall) begin
                // A partial pixel left in the shifter is simply abandoned.
                beat_d     = '0;
                line_odd_d = ~line_odd_q;
                if (line_kept) begin
                    line_cnt_d   = sat_inc(line_cnt_q);
                    last_width_d = pix_cnt_q;
                end
            end
            if (shift_en) begin
                shreg_d = shreg_shift;
                if (beat_d == LAST_BEAT) begin
                    beat_d = '0;
                    if (!decim_on || (!line_odd_q && !pix_odd_d)) begin
                        push       = 1'b1;
                        push_word  = {sof_pend_d, sol_pend_d, shreg_shift};
                        sof_pend_d = 1'b0;
                        sol_pend_d = 1'b0;
                        pix_cnt_d  = sat_inc(pix_cnt_d);
                    end
                    pix_odd_d = ~pix_odd_d;
                end else begin
                    beat_d = beat_d + 1'b1;
                end
            end
        end else begin
            beat_d = '0;
        end
    end

    // Assembly registers and latched frame geometry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_q       <= '0;
            shreg_q      <= '0;
            sof_pend_q   <= 1'b0;
            sol_pend_q   <= 1'b0;
            pix_cnt_q    <= '0;
            pix_odd_q    <= 1'b0;
            line_cnt_q   <= '0;
            line_odd_q   <= 1'b0;
            last_width_q <= '0;
            line_width   <= '0;
            frame_lines  <= '0;
            frame_done   <= 1'b0;
        end else begin
            beat_q       <= beat_d;
            shreg_q      <= shreg_d;
            sof_pend_q   <= sof_pend_d;
            sol_pend_q   <= sol_pend_d;
            pix_cnt_q    <= pix_cnt_d;
            pix_odd_q    <= pix_odd_d;
            line_cnt_q   <= line_cnt_d;
            line_odd_q   <= line_odd_d;
            last_width_q <= last_width_d;
            frame_done   <= frame_end;
            if (frame_end) begin
                line_width  <= last_width_q;
                frame_lines <= line_cnt_q;
            end
        end
    end

    // ---------------- pixel FIFO (show-ahead) ----------------
    logic [PIX_W+1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic             empty, full, pop, push_ok, drop;
    logic [PIX_W+1:0] rd_word;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop     = !empty && pix_ready;
    // A full FIFO still takes a pixel when a pop frees a slot on the same edge.
    assign push_ok = push && (!full || pop);
    assign drop    = push && full && !pop;
    assign rd_word = mem_q[rd_ptr_q[AW-1:0]];

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_word;
    end

    // Pointers and the sticky overflow flag (a new drop beats a clear).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            if (drop)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

    assign pix_valid = !empty;
    assign pix_data  = empty ? '0 : rd_word[PIX_W-1:0];
    assign pix_sol   = empty ? 1'b0 : rd_word[PIX_W];
    assign pix_sof   = empty ? 1'b0 : rd_word[PIX_W+1];

endmodule

// File: tb/tb_dvp_frame_capture.sv
// tb_dvp_frame_capture: directed bench for dvp_frame_capture. It uses a
// frame-geometry vector table plus hand-written sequences for arming, overflow
// and reset corner cases. Pixel stream contents go through an expected queue.
`timescale 1ns/1ps
module tb_dvp_frame_capture;

    localparam int DATA_W = 8;
    localparam int BPP    = 2;
    localparam int DEPTH  = 64;
    localparam int XDIV   = 4;
    localparam int CNT_W  = 12;
    localparam int PIX_W  = BPP * DATA_W;

    logic               clk = 1'b0;
    logic               reset_n = 1'b1;
    logic               cam_pclk = 1'b0, cam_vsync = 1'b1, cam_href = 1'b0;
    logic [DATA_W-1:0]  cam_data = '0;
    logic               cam_xclk;
    logic               ctrl_enable = 1'b0, ctrl_single = 1'b0, ctrl_arm = 1'b0;
    logic               ovf_clr = 1'b0, pix_ready = 1'b0;
    logic [PIX_W-1:0]   pix_data;
    logic               pix_sof, pix_sol, pix_valid;
    logic               busy, frame_done, overflow;
    logic [CNT_W-1:0]   line_width, frame_lines;
    logic [1:0]         dbg_state;

    dvp_frame_capture #(
        .DATA_W(DATA_W), .BYTES_PER_PIX(BPP), .FIFO_DEPTH(DEPTH),
        .XCLK_DIV(XDIV), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href),
        .cam_data(cam_data), .cam_xclk(cam_xclk),
        .ctrl_enable(ctrl_enable), .ctrl_single(ctrl_single),
        .ctrl_arm(ctrl_arm), .ovf_clr(ovf_clr),
        .pix_data(pix_data), .pix_sof(pix_sof), .pix_sol(pix_sol),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .busy(busy), .frame_done(frame_done), .overflow(overflow),
        .line_width(line_width), .frame_lines(frame_lines),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int tests_run = 0;
    int tests_failed = 0;
    int done_cnt = 0;
    int exp_done = 0;
    logic [PIX_W+1:0] exp_q[$];

    // camera-side model state
    bit               cap_on = 1'b0;
    bit               sof_m = 1'b0, sol_m = 1'b0;
    int               beat_m = 0;
    logic [PIX_W-1:0] pix_m = '0;
    logic [7:0]       byte_seq = 8'h12;

    typedef struct {
        int lines;
        int nbytes;
        int exp_width;
        int exp_lines;
    } vec_t;
    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clk cycle. Outputs are sampled at the falling edge and checked
    // against the scoreboard. Inputs are then driven 2 ns after the rising edge.
    task automatic tick();
        logic [PIX_W+1:0] e;
        @(negedge clk);
        if (frame_done === 1'b1) done_cnt++;
        if (reset_n && pix_valid === 1'b1 && pix_ready) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL sb_unexpected: got pixel 0x%0h, none expected",
                         {pix_sof, pix_sol, pix_data});
            end else begin
                e = exp_q.pop_front();
                if ({pix_sof, pix_sol, pix_data} !== e) begin
                    tests_failed++;
                    $display("FAIL sb_pixel: got {sof,sol,data}=0x%0h expected 0x%0h",
                             {pix_sof, pix_sol, pix_data}, e);
                end
            end
        end
        @(posedge clk);
        #2;
    endtask

    // ---------------- camera driver tasks ----------------
    // A pclk period is 8 clk cycles. keep_full also pulses pix_ready on the
    // exact edge where this byte's pixel is pushed, so a full FIFO pops and
    // pushes on the same edge.
    task automatic send_byte(input logic [7:0] d, input bit keep_full);
        cam_data = d;
        cam_pclk = 1'b0;
        repeat (4) tick();
        cam_pclk = 1'b1;
        if (cap_on) begin
            pix_m = {pix_m[PIX_W-DATA_W-1:0], d};
            beat_m++;
            if (beat_m == BPP) begin
                beat_m = 0;
                if (exp_q.size() < DEPTH || keep_full)
                    exp_q.push_back({sof_m, sol_m, pix_m});
                sof_m = 1'b0;
                sol_m = 1'b0;
            end
        end
        if (keep_full) begin
            tick();
            tick();
            pix_ready = 1'b1;
            tick();
            pix_ready = 1'b0;
            tick();
        end else begin
            repeat (4) tick();
        end
    endtask

    task automatic line_start();
        cam_href = 1'b1;
        sol_m    = cap_on;
        beat_m   = 0;
        repeat (4) tick();
    endtask

    task automatic line_end();
        cam_pclk = 1'b0;
        cam_href = 1'b0;
        repeat (12) tick();
    endtask

    task automatic send_line(input int nbytes);
        line_start();
        for (int i = 0; i < nbytes; i++) begin
            send_byte(byte_seq, 1'b0);
            byte_seq = byte_seq + 8'h22;
        end
        line_end();
    endtask

    task automatic send_frame(input int lines, input int nbytes, input bit cap);
        cap_on    = cap;
        sof_m     = cap;
        cam_vsync = 1'b0;
        repeat (16) tick();
        for (int l = 0; l < lines; l++) send_line(nbytes);
        cam_vsync = 1'b1;
        repeat (16) tick();
        cap_on = 1'b0;
    endtask

    task automatic pulse_arm();
        ctrl_arm = 1'b1;
        tick();
        ctrl_arm = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic xs[8];
        int   ones;
        int   viol;

        vecs[0] = '{lines: 4, nbytes: 12, exp_width: 6, exp_lines: 4};
        vecs[1] = '{lines: 3, nbytes: 7,  exp_width: 3, exp_lines: 3};
        vecs[2] = '{lines: 2, nbytes: 9,  exp_width: 4, exp_lines: 2};
        vecs[3] = '{lines: 5, nbytes: 2,  exp_width: 1, exp_lines: 5};

        // reset state
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_pix_valid", pix_valid, 0);
        check("rst_pix_data", pix_data, 0);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);
        check("rst_line_width", line_width, 0);
        check("rst_frame_lines", frame_lines, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_xclk", cam_xclk, 0);
        check("rst_state", dbg_state, 0);
        reset_n = 1'b1;
        repeat (2) tick();

        // cam_xclk: period 4 clk, 50% duty
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            xs[i] = cam_xclk;
        end
        @(posedge clk);
        #2;
        ones = 0;
        viol = 0;
        for (int i = 0; i < 8; i++) if (xs[i]) ones++;
        for (int i = 0; i < 6; i++) if (xs[i] == xs[i+2]) viol++;
        check("xclk_duty", ones, 4);
        check("xclk_period", viol, 0);

        // continuous capture, table of frame geometries
        ctrl_enable = 1'b1;
        ctrl_single = 1'b0;
        pix_ready   = 1'b1;
        tick();
        for (int v = 0; v < 4; v++) begin
            send_frame(vecs[v].lines, vecs[v].nbytes, 1'b1);
            exp_done++;
            check("tbl_line_width", line_width, vecs[v].exp_width);
            check("tbl_frame_lines", frame_lines, vecs[v].exp_lines);
            check("tbl_frame_done", done_cnt, exp_done);
            check("tbl_sb_drained", exp_q.size(), 0);
        end

        // disable -> IDLE
        ctrl_enable = 1'b0;
        repeat (2) tick();
        check("dis_busy", busy, 0);
        check("dis_state", dbg_state, 0);

        // enable mid-frame: remainder of that frame must not be captured
        cam_vsync = 1'b0;
        repeat (16) tick();
        send_line(4);
        ctrl_enable = 1'b1;
        send_line(4);
        cam_vsync = 1'b1;
        repeat (16) tick();
        check("mid_no_pixels", pix_valid, 0);
        check("mid_no_done", done_cnt, exp_done);
        send_frame(2, 4, 1'b1);
        exp_done++;
        check("mid_next_done", done_cnt, exp_done);
        check("mid_next_width", line_width, 2);
        check("mid_sb_drained", exp_q.size(), 0);

        // single-shot: one arm captures exactly one frame
        ctrl_enable = 1'b0;
        tick();
        ctrl_single = 1'b1;
        ctrl_enable = 1'b1;
        repeat (4) tick();
        check("ss_unarmed_busy", busy, 0);
        pulse_arm();
        tick();
        check("ss_armed_busy", busy, 1);
        send_frame(2, 6, 1'b1);
        exp_done++;
        send_frame(2, 6, 1'b0);
        send_frame(2, 6, 1'b0);
        check("ss_done_once", done_cnt, exp_done);
        check("ss_busy_after", busy, 0);
        check("ss_state_idle", dbg_state, 0);
        check("ss_frame_lines", frame_lines, 2);
        check("ss_sb_drained", exp_q.size(), 0);
        pulse_arm();
        send_frame(1, 4, 1'b1);
        exp_done++;
        check("ss_rearm_done", done_cnt, exp_done);
        check("ss_rearm_lines", frame_lines, 1);
        check("ss_rearm_sb", exp_q.size(), 0);

        // overflow: 100-pixel line with pix_ready low
        ctrl_single = 1'b0;
        pix_ready   = 1'b0;
        tick();
        send_frame(1, 200, 1'b1);
        exp_done++;
        check("ovf_set", overflow, 1);
        check("ovf_fifo_size", exp_q.size(), DEPTH);
        check("ovf_line_width", line_width, 100);
        pix_ready = 1'b1;
        repeat (100) tick();
        check("ovf_drained", exp_q.size(), 0);
        check("ovf_valid_low", pix_valid, 0);
        check("ovf_sticky", overflow, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        tick();
        check("ovf_cleared", overflow, 0);

        // full FIFO with pop and push on the same edge: no drop
        pix_ready = 1'b0;
        cap_on    = 1'b1;
        sof_m     = 1'b1;
        cam_vsync = 1'b0;
        repeat (16) tick();
        line_start();
        for (int i = 0; i < 129; i++) begin
            send_byte(byte_seq, 1'b0);
            byte_seq = byte_seq + 8'h22;
        end
        check("full_no_ovf_yet", overflow, 0);
        send_byte(byte_seq, 1'b1);
        byte_seq = byte_seq + 8'h22;
        line_end();
        cam_vsync = 1'b1;
        repeat (16) tick();
        cap_on = 1'b0;
        exp_done++;
        check("full_poppush_no_ovf", overflow, 0);
        check("full_line_width", line_width, 65);
        pix_ready = 1'b1;
        repeat (100) tick();
        check("full_drained", exp_q.size(), 0);
        check("full_done_cnt", done_cnt, exp_done);

        // asynchronous reset in the middle of a frame
        pix_ready = 1'b0;
        cap_on    = 1'b1;
        sof_m     = 1'b1;
        cam_vsync = 1'b0;
        repeat (16) tick();
        line_start();
        for (int i = 0; i < 6; i++) begin
            send_byte(byte_seq, 1'b0);
            byte_seq = byte_seq + 8'h22;
        end
        check("pre_rst_valid", pix_valid, 1);
        check("pre_rst_busy", busy, 1);
        #1 reset_n = 1'b0;
        #1;
        check("mid_rst_valid", pix_valid, 0);
        check("mid_rst_data", pix_data, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_width", line_width, 0);
        check("mid_rst_lines", frame_lines, 0);
        check("mid_rst_ovf", overflow, 0);
        check("mid_rst_xclk", cam_xclk, 0);
        check("mid_rst_done", frame_done, 0);
        exp_q.delete();
        cap_on   = 1'b0;
        cam_href = 1'b0;
        cam_pclk = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/dvp_frame_capture.md
Name: dvp_frame_capture

Overview:
- Parametrised successor to the single-camera DVP hookup: captures OV7670-class parallel camera video (PCLK, VSYNC, HREF, DATA) into the system clock domain and assembles bytes into pixels.
- Buffers pixels in an on-chip FIFO and presents them as a valid/ready stream with start-of-frame and start-of-line tags.
- Generates the camera master clock, supports continuous and single-shot (shutter) capture, and reports frame geometry and overflow status.
- Sits between the GPIO camera pins and the Avalon-side frame writer.

Parameters:
- DATA_W, 8, camera data bus width in bits.
- BYTES_PER_PIX, 2, camera beats per pixel (1..4).
- FIFO_DEPTH, 64, pixel FIFO entries (power of two, ≥4).
- XCLK_DIV, 2, clk cycles per cam_xclk period (even, ≥2).
- CNT_W, 12, width of the line/pixel counters.

Ports:
- clk  in  1  system clock; everything is clocked by clk.
- reset_n  in  1  asynchronous active-low reset.
- cam_pclk  in  1  camera pixel clock, treated as data and oversampled; f(pclk) ≤ f(clk)/4.
- cam_vsync  in  1  frame sync; high during vertical blanking.
- cam_href  in  1  line valid.
- cam_data  in  DATA_W  camera data.
- cam_xclk  out  1  camera master clock.
- ctrl_enable  in  1  capture enable.
- ctrl_single  in  1  1 = single-shot mode, 0 = continuous.
- ctrl_arm  in  1  one-cycle pulse; requests one frame in single-shot mode.
- ovf_clr  in  1  clears overflow.
- pix_data  out  BYTES_PER_PIX*DATA_W  pixel; first beat in the MSBs.
- pix_sof  out  1  tag: first pixel of the frame.
- pix_sol  out  1  tag: first pixel of the line.
- pix_valid  out  1  stream valid.
- pix_ready  in  1  stream ready.
- busy  out  1  state is WAIT_VS or CAPTURE.
- frame_done  out  1  one-cycle pulse at the end of each captured frame.
- overflow  out  1  sticky drop flag.
- line_width  out  CNT_W  pixels in the last complete line of the last frame.
- frame_lines  out  CNT_W  lines in the last frame.

Behaviour:
- Reset: all outputs and state are 0; FIFO is empty; FSM is in IDLE.
- Input sync: pclk, vsync, href and data each pass through a 2-flop synchroniser.
  - A pclk rise is sync2 & ~sync3.
  - Data is sampled on that cycle (same delay as pclk, so aligned).
  - Sync latency is 3 clk cycles.
- xclk: cam_xclk toggles every XCLK_DIV/2 clk cycles whenever reset_n is high, independent of ctrl_enable.
- FSM states:
  - IDLE: enter WAIT_VS if ctrl_enable and (!ctrl_single, or ctrl_arm seen this cycle).
  - WAIT_VS: wait for a vsync falling edge, then enter CAPTURE. A frame already in progress is never captured partially.
  - CAPTURE: collect pixels. On a vsync rising edge:
    - latch frame_lines and line_width;
    - pulse frame_done;
    - go to WAIT_VS if continuous, else IDLE.
  - ctrl_enable low in any state: go to IDLE next cycle and discard the partial pixel. FIFO contents are kept.
  - ctrl_arm in continuous mode or outside IDLE is ignored.
- Byte assembly:
  - The beat counter resets on each href rising edge.
  - Each pclk rise with href high shifts in one beat; after BYTES_PER_PIX beats a pixel is pushed.
  - A partial pixel at href fall is discarded.
- Tags and counters:
  - sof is set on the first pixel after entering CAPTURE.
  - sol is set on the first pixel after each href rise.
  - The pixel counter saturates at 2^CNT_W-1.
  - The line counter increments on href fall.
  - line_width holds the count of the last line that ended before vsync rose.
- FIFO:
  - pix_valid = !empty. A pop happens when pix_valid & pix_ready.
  - A push when full is accepted only if a pop occurs in the same cycle. Otherwise the pixel is dropped and overflow is set.
  - overflow clears on ovf_clr; a simultaneous set wins.
  - Read latency: a pushed pixel appears on pix_data 1 cycle after the push (show-ahead).

Optional Feature:
- Macro: DVP_DECIMATE_EN.
- Defined: adds input ctrl_decim.
  - When ctrl_decim=1, only even pixels of even lines are pushed (2x2 decimation).
  - line_width and frame_lines report the decimated counts.
  - sol marks the first kept pixel of each kept line.
- Undefined: the port is absent and every pixel is pushed.

Test Plan:
- Continuous mode, 4 lines × 6 pixels, BYTES_PER_PIX=2, bytes 0x12,0x34… -> pixels 0x1234…; sof on pixel 0 only; sol on 4 pixels; line_width=6, frame_lines=4; one frame_done.
- Enable asserted mid-frame (vsync low) -> nothing pushed until after the next vsync fall; first pushed pixel has sof=1.
- Single-shot: arm, stream 3 frames -> exactly one frame captured, state IDLE, busy=0; a second arm captures the next full frame.
- Hold pix_ready=0, FIFO_DEPTH=64, 100-pixel line -> 64 pixels retained, overflow=1; ovf_clr -> 0; pop/push when full -> no drop.
- Odd beat count (7 bytes) on a line with BYTES_PER_PIX=2 -> 3 pixels; trailing byte discarded; next line realigned.
- XCLK_DIV=4 -> cam_xclk period 4 clk cycles, 50% duty; reset_n low mid-frame -> all outputs 0 immediately.
